// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, stall levels, load/store codes, ex-to-mem bus layout and hold-buffer states
package mem_stage_pkg;
  localparam int EX_TO_MEM_WD = 80;
  localparam int MEM_TO_WB_WD = 70;
  localparam int STALL_BUS = 6;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic [3:0] LW = 4'b0000;
  localparam logic [3:0] LB = 4'b0001;
  localparam logic [3:0] LBU = 4'b0010;
  localparam logic [3:0] LH = 4'b0011;
  localparam logic [3:0] LHU = 4'b0100;
  localparam logic [3:0] SB = 4'b0101;
  localparam logic [3:0] SH = 4'b0111;
  typedef enum logic {EMPTY, FULL} hold_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic data_ram_en;
    logic [3:0] data_ram_wen;
    logic sel_rf_res;
    logic rf_we;
    logic [4:0] rf_waddr;
    logic [31:0] ex_result;
    logic [3:0] data_ram_read;
  } ex_to_mem_t;
  function automatic logic is_load(ex_to_mem_t e);
    return e.data_ram_en && e.data_ram_wen == 4'b0000;
  endfunction
endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: picks byte/halfword/word of rdata by data_ram_read and addr[1:0], then sign/zero-extends to 32 bits
module load_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  data_ram_read,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  logic [7:0] b;
  logic [15:0] h;
  logic is_store;
  assign b = addr[1] ? (addr[0] ? rdata[31:24] : rdata[23:16]) : (addr[0] ? rdata[15:8] : rdata[7:0]);
  assign h = addr[1] ? rdata[31:16] : rdata[15:0];
  assign is_store = data_ram_read == SB || data_ram_read == SH;
  assign data = is_store               ? 32'h0 :
                data_ram_read == LB  ? {{24{b[7]}}, b} :
                data_ram_read == LBU ? {24'h0, b} :
                data_ram_read == LH  ? {{16{h[15]}}, h} :
                data_ram_read == LHU ? {16'h0, h} :
                data_ram_read == LW  ? rdata : 32'h0;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: ex->mem register, load align + hold buffer; ports clk, rst, stall, ex_to_mem_bus, data_sram_rdata -> mem_to_wb_bus, mem_to_id_bus, mem_is_load
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_id_bus,
  output logic                    mem_is_load
);
  ex_to_mem_t r;
  hold_state_t state;
  logic [31:0] hold_data, rdata_eff, load_data, rf_wdata;
  logic bubble, advance, unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};
  assign bubble = stall[3] == STOP && stall[4] == NO_STOP;
  assign advance = stall[3] == NO_STOP || bubble;
  always_ff @(posedge clk or posedge rst)
    if (rst) r <= '0;
    else if (bubble) r <= '0;
    else if (stall[3] == NO_STOP) r <= ex_to_mem_bus;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= EMPTY;
      hold_data <= '0;
    end else if (advance) state <= EMPTY;
    else if (state == EMPTY && mem_is_load && stall[4] == STOP) begin
      state <= FULL;
      hold_data <= data_sram_rdata;
    end
  assign mem_is_load = is_load(r);
  assign rdata_eff = state == FULL ? hold_data : data_sram_rdata;
  load_align u_align (
    .data_ram_read(r.data_ram_read),
    .addr(r.ex_result[1:0]),
    .rdata(rdata_eff),
    .data(load_data)
  );
  assign rf_wdata = r.sel_rf_res ? load_data : r.ex_result;
  assign mem_to_id_bus = {r.rf_we, r.rf_waddr, rf_wdata};
  assign mem_to_wb_bus = {r.pc, mem_to_id_bus};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized + directed check of mem_stage against a behavioural model
module tb_mem_stage;
  logic clk = 0, rst = 0;
  logic [5:0] stall = 0;
  logic [79:0] bus = 0;
  logic [31:0] rdata = 0;
  logic [69:0] wb;
  logic [37:0] id;
  logic ld;
  int errors = 0, checks = 0;
  mem_stage dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .ex_to_mem_bus(bus),
    .data_sram_rdata(rdata),
    .mem_to_wb_bus(wb),
    .mem_to_id_bus(id),
    .mem_is_load(ld)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [79:0] mk(logic [31:0] pc, logic [3:0] code, logic l, logic we, logic [4:0] wa, logic [31:0] res);
    return {pc, l, 4'b0000, l, we, wa, res, code};
  endfunction
  logic [79:0] m_reg = 0;
  logic m_frz = 0;
  logic [31:0] m_hold = 0;
  function automatic logic [31:0] align(logic [3:0] c, logic [1:0] a, logic [31:0] d);
    logic [31:0] b = d >> (8 * a);
    logic [31:0] h = d >> (16 * a[1]);
    case (c)
      4'b0001: return {{24{b[7]}}, b[7:0]};
      4'b0010: return {24'h0, b[7:0]};
      4'b0011: return {{16{h[15]}}, h[15:0]};
      4'b0100: return {16'h0, h[15:0]};
      4'b0000: return d;
      default: return 32'h0;
    endcase
  endfunction
  function automatic logic [69:0] exp_wb();
    logic [31:0] d = m_frz ? m_hold : rdata;
    logic [31:0] w = m_reg[42] ? align(m_reg[3:0], m_reg[5:4], d) : m_reg[35:4];
    return {m_reg[79:48], m_reg[41], m_reg[40:36], w};
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_reg = 0;
      m_frz = 0;
      m_hold = 0;
    end else begin
      if (stall[3] && stall[4] && !m_frz && m_reg[47] && m_reg[46:43] == 0) begin
        m_frz = 1;
        m_hold = rdata;
      end else if (!(stall[3] && stall[4])) m_frz = 0;
      if (!stall[3]) m_reg = bus;
      else if (!stall[4]) m_reg = 0;
    end
  logic [69:0] e;
  always @(negedge clk) begin
    e = exp_wb();
    chk("wb_bus", wb, e);
    chk("id_bus", id, e[37:0]);
    chk("is_load", ld, m_reg[47] && m_reg[46:43] == 0);
  end
  initial begin
    logic [3:0] c;
    logic l, en;
    int r;
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_wb", wb, 70'h0);
    bus = mk(32'h100, 4'b0001, 1, 1, 5'd3, 32'h1003);
    tick;
    rdata = 32'h80FF_1234;
    bus = mk(32'h104, 4'b0010, 1, 1, 5'd3, 32'h1003);
    @(negedge clk);
    chk("lb", wb[31:0], 32'hFFFF_FF80);
    tick;
    @(negedge clk);
    chk("lbu", wb[31:0], 32'h0000_0080);
    bus = mk(32'h108, 4'b0011, 1, 1, 5'd4, 32'h3002);
    tick;
    rdata = 32'h8001_7FFF;
    bus = mk(32'h10C, 4'b0100, 1, 1, 5'd4, 32'h3000);
    @(negedge clk);
    chk("lh", wb[31:0], 32'hFFFF_8001);
    tick;
    @(negedge clk);
    chk("lhu", wb[31:0], 32'h0000_7FFF);
    bus = mk(32'h110, 4'b0000, 1, 1, 5'd6, 32'h4000);
    tick;
    stall = 6'b011111;
    rdata = 32'h1111_1111;
    @(negedge clk);
    chk("hold0", wb[31:0], 32'h1111_1111);
    tick;
    rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("hold1", wb[31:0], 32'h1111_1111);
    tick;
    @(negedge clk);
    chk("hold2", wb[31:0], 32'h1111_1111);
    stall = 0;
    bus = mk(32'h114, 4'b0000, 1, 1, 5'd6, 32'h4004);
    tick;
    rdata = 32'h1234_5678;
    @(negedge clk);
    chk("hold_empty", wb[31:0], 32'h1234_5678);
    stall = 6'b001111;
    tick;
    @(negedge clk);
    chk("bubble", wb[69:37], 33'h0);
    stall = 0;
    bus = mk(32'h200, 4'b0000, 0, 1, 5'd7, 32'h42);
    tick;
    rdata = $urandom;
    @(negedge clk);
    chk("alu", wb[31:0], 32'h42);
    bus = mk(32'h204, 4'b0000, 1, 1, 5'd5, 32'h5000);
    tick;
    rdata = 32'hCAFE_F00D;
    bus = mk(32'h208, 4'b0000, 0, 1, 5'd5, 32'h1234);
    @(negedge clk);
    chk("fwd_load", id, {1'b1, 5'd5, 32'hCAFE_F00D});
    tick;
    @(negedge clk);
    chk("fwd_add", id, {1'b1, 5'd5, 32'h0000_1234});
    bus = mk(32'h300, 4'b0000, 1, 1, 5'd9, 32'h6000);
    tick;
    stall = 6'b011111;
    rdata = 32'hAAAA_5555;
    tick;
    #2 rst = 1;
    #1;
    chk("rst_wb", wb, 70'h0);
    chk("rst_id", id, 38'h0);
    @(posedge clk);
    #1 rst = 0;
    stall = 0;
    bus = mk(32'h304, 4'b0000, 1, 1, 5'd9, 32'h6004);
    tick;
    rdata = 32'h0000_0077;
    @(negedge clk);
    chk("rst_discard", wb[31:0], 32'h0000_0077);
    repeat (400) begin
      r = $urandom_range(0, 9);
      stall = r < 5 ? 6'b000000 : r < 7 ? 6'b011111 : r < 9 ? 6'b001111 : 6'b010000;
      l = 1'($urandom_range(0, 1));
      if (l) begin
        c = 4'($urandom_range(0, 4));
        bus = {32'($urandom), 1'b1, 4'b0000, 1'b1, 1'b1, 5'($urandom), 32'($urandom), c};
      end else begin
        r = $urandom_range(0, 2);
        c = r == 0 ? 4'b0000 : r == 1 ? 4'b0101 : 4'b0111;
        en = 1'($urandom_range(0, 1));
        bus = {32'($urandom), en, en ? 4'($urandom_range(1, 15)) : 4'b0000, 1'b0, 1'($urandom), 5'($urandom), 32'($urandom), c};
      end
      rdata = $urandom;
      tick;
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
